clock_domain_export_fifo: RTL and testbench
===========================================

CLOCK_DOMAIN_EXPORT_FIFO -- requirements
Module: clock_domain_export_fifo

Interface
REQ-001 Parameter SIZE, default 8, width of each data word, SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4, source-side queue depth in words, SHALL be a power of two >= 2.
REQ-003 Parameter SYNC_STAGES, default 2, number of flops on the handshake_ack synchronizer, SHALL be >= 2.
REQ-004 clk  input  1  single clock, all sequential logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 data  input  SIZE  word to queue, sampled when stb is high.
REQ-007 stb  input  1  one-cycle request to queue data.
REQ-008 busy  output  1  queue full, so stb is not accepted this cycle.
REQ-009 level  output  $clog2(DEPTH)+1  words queued, not counting the word in flight.
REQ-010 overflow  output  1  one-cycle pulse when a stb is dropped.
REQ-011 idle  output  1  high when the queue is empty and no handshake is in progress.
REQ-012 handshake_data  output  SIZE  word presented to the other domain.
REQ-013 handshake_valid  output  1  word on handshake_data is valid; driven by this block.
REQ-014 handshake_ack  input  1  acknowledge from the other clock domain; asynchronous to clk.

Function
REQ-015 A stb at an edge where busy is low SHALL write data at the queue tail, and level SHALL increment at that edge.
REQ-016 A stb at an edge where busy is high SHALL discard data, SHALL leave queue contents unchanged, and SHALL drive overflow high for exactly the following cycle.
REQ-017 busy SHALL equal (level == DEPTH), decoded from registered state only, with no combinational path from stb.
REQ-018 A write and a pop at the same edge SHALL leave level unchanged and SHALL preserve FIFO order.
REQ-019 Read and write pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0 without a gap.
REQ-020 handshake_ack SHALL pass through a SYNC_STAGES-flop chain; the FSM SHALL use only the last stage (ack_s).
REQ-021 The FSM SHALL have 3 states: IDLE, WAIT_ACK, WAIT_RELEASE.
REQ-022 IDLE with level > 0: at the next edge, pop the head into handshake_data, set handshake_valid to 1, and go to WAIT_ACK.
REQ-023 IDLE with level == 0: hold, with handshake_valid at 0.
REQ-024 WAIT_ACK with ack_s == 1: set handshake_valid to 0 and go to WAIT_RELEASE.
REQ-025 WAIT_ACK with ack_s == 0: hold.
REQ-026 WAIT_RELEASE with ack_s == 0: go to IDLE.
REQ-027 WAIT_RELEASE with ack_s == 1: hold.
REQ-028 handshake_data SHALL change only at the pop edge, and SHALL be stable from that edge until the FSM next leaves IDLE.
REQ-029 handshake_data and handshake_valid SHALL be driven directly from flops, with no combinational logic after them.
REQ-030 Latency: if stb is sampled at edge N into an empty queue while in IDLE, handshake_valid SHALL be high after edge N+1.
REQ-031 Back-to-back transfers: the next pop SHALL occur no earlier than the edge after the FSM returns to IDLE.
REQ-032 idle SHALL equal (state == IDLE) && (level == 0).
REQ-033 handshake_ack rising while in IDLE SHALL be ignored and SHALL NOT corrupt the queue.
REQ-034 handshake_ack falling while in WAIT_ACK SHALL be ignored and SHALL NOT corrupt the queue.

Reset
REQ-035 rst_n low SHALL immediately force: state IDLE, pointers and level 0, handshake_valid 0, handshake_data 0, overflow 0, all synchronizer flops 0.
REQ-036 Reset asserted mid-handshake SHALL discard the in-flight word and all queued words; no word SHALL be re-presented after reset.
REQ-037 Reset release SHALL be sampled only on rising clk; no stb SHALL be accepted on the first edge at which rst_n is high.
REQ-038 Queue storage SHALL NOT require reset; only pointers and control SHALL reset.

Verification
REQ-039 Single word (SIZE=8, DEPTH=4, SYNC_STAGES=2): stb with data=0xA5 into an empty queue -> handshake_valid high one edge later with handshake_data=0xA5; bench raises ack -> valid low 3 edges later; bench drops ack -> FSM in IDLE 3 edges later, idle=1.
REQ-040 Fill and overflow: with ack held low, 5 stbs carrying 0x01..0x05 -> first word in flight, level=4 and busy=1 after the 5th; a 6th stb of 0x06 -> overflow pulses once; the words delivered over the handshake are exactly 0x01..0x05.
REQ-041 Pointer wrap: 12 words 0x10..0x1B, with stb timed to keep the queue partly full -> all 12 delivered in order, with no overflow.
REQ-042 Simultaneous push and pop: stb at the same edge as the IDLE pop with level=2 -> level stays 2 and order is preserved.
REQ-043 Reset mid-transfer: assert rst_n low in WAIT_ACK with level=3 -> handshake_valid 0 immediately, level=0, idle=1; after release a new stb of 0x77 -> 0x77 is the next word delivered.
REQ-044 Spurious ack: pulse handshake_ack while in IDLE with an empty queue -> no handshake_valid, level stays 0, overflow stays 0.

Source files
------------

// File: rtl/clock_domain_export_fifo.sv
// Source-side word queue that exports one word at a time to another clock domain
// over a four-phase valid/ack handshake; the returning ack is synchronised locally.
module clock_domain_export_fifo #(
  parameter int SIZE        = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SIZE-1:0]          data,
  input  logic                     stb,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     idle,
  output logic [SIZE-1:0]          handshake_data,
  output logic                     handshake_valid,
  input  logic                     handshake_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RELEASE
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [SIZE-1:0]        hs_data_q, hs_data_d;
  logic                   hs_valid_q, hs_valid_d;
  logic                   overflow_q, overflow_d;
  logic                   armed_q, armed_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [SIZE-1:0]        mem_q [DEPTH];

  logic ack_s;
  logic push;
  logic pop;

  assign busy            = (level_q == LVL_W'(DEPTH));
  assign level           = level_q;
  assign overflow        = overflow_q;
  assign idle            = (state_q == IDLE) && (level_q == '0);
  assign handshake_data  = hs_data_q;
  assign handshake_valid = hs_valid_q;

  // armed_q is low for the first edge after reset release so a stb there is ignored
  always_comb begin
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], handshake_ack};
    ack_s      = ack_sync_q[SYNC_STAGES-1];
    armed_d    = 1'b1;
    push       = stb && !busy && armed_q;
    pop        = (state_q == IDLE) && (level_q != '0);
    overflow_d = stb && busy && armed_q;
  end

  always_comb begin
    state_d    = state_q;
    hs_valid_d = hs_valid_q;
    hs_data_d  = hs_data_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          hs_data_d  = mem_q[rd_ptr_q];
          hs_valid_d = 1'b1;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s) begin
          hs_valid_d = 1'b0;
          state_d    = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!ack_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        hs_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      hs_data_q  <= '0;
      hs_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      armed_q    <= 1'b0;
      ack_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      hs_data_q  <= hs_data_d;
      hs_valid_q <= hs_valid_d;
      overflow_q <= overflow_d;
      armed_q    <= armed_d;
      ack_sync_q <= ack_sync_d;
    end
  end

  // Storage carries no reset; only pointers and level define what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

endmodule

// File: tb/tb_clock_domain_export_fifo.sv
// Bench for clock_domain_export_fifo: directed scenarios plus random traffic,
// with a queue-based model scoring every delivered word, level, busy and overflow.
module tb_clock_domain_export_fifo;

  localparam int SIZE  = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [SIZE-1:0] data;
  logic            stb;
  logic            busy;
  logic [2:0]      level;
  logic            overflow;
  logic            idle;
  logic [SIZE-1:0] handshake_data;
  logic            handshake_valid;
  logic            ack;

  int n_total = 0;
  int n_pass  = 0;
  bit auto_ack = 1'b0;

  clock_domain_export_fifo #(
    .SIZE(SIZE),
    .DEPTH(DEPTH),
    .SYNC_STAGES(2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data            (data),
    .stb             (stb),
    .busy            (busy),
    .level           (level),
    .overflow        (overflow),
    .idle            (idle),
    .handshake_data  (handshake_data),
    .handshake_valid (handshake_valid),
    .handshake_ack   (ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: accepted words in order, plus count of words still queued.
  logic [SIZE-1:0] exp_q[$];
  int              mlevel     = 0;
  bit              armed      = 1'b0;
  bit              s_acc      = 1'b0;
  bit              s_ovf      = 1'b0;
  bit              prev_valid = 1'b0;
  logic [SIZE-1:0] held       = '0;

  always begin
    @(posedge clk);
    s_acc = rst_n && armed && stb && (mlevel < DEPTH);
    s_ovf = rst_n && armed && stb && (mlevel >= DEPTH);
    if (s_acc) exp_q.push_back(data);
    armed = rst_n;
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      mlevel = 0;
      armed  = 1'b0;
      held   = '0;
      chk("rst_valid", handshake_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_data", handshake_data, 0);
    end else begin
      if (handshake_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          held = exp_q.pop_front();
          chk("word", handshake_data, held);
          mlevel--;
        end
      end else begin
        chk("data_stable", handshake_data, held);
      end
      if (s_acc) mlevel++;
      chk("level", level, mlevel);
      chk("busy", busy, mlevel == DEPTH);
      chk("overflow", overflow, s_ovf);
    end
    prev_valid = handshake_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ack) begin
      if (handshake_valid && !ack) begin
        if ($urandom_range(0, 2) == 0) ack = 1'b1;
      end else if (!handshake_valid && ack) begin
        if ($urandom_range(0, 2) == 0) ack = 1'b0;
      end
    end
  endtask

  task automatic wait_valid(input logic v);
    int n = 0;
    while (handshake_valid !== v && n < 60) begin
      tick();
      n++;
    end
    chk("wait_valid", handshake_valid, v);
  endtask

  task automatic deliver(input int n);
    for (int i = 0; i < n; i++) begin
      wait_valid(1'b1);
      ack = 1'b1;
      wait_valid(1'b0);
      ack = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic drain();
    int n = 0;
    while (!(idle && !ack) && n < 400) begin
      tick();
      n++;
    end
    chk("drain_timeout", n < 400, 1);
    chk("all_delivered", exp_q.size(), 0);
  endtask

  task automatic push(input logic [SIZE-1:0] d);
    stb  = 1'b1;
    data = d;
    tick();
    stb  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    stb   = 1'b0;
    data  = '0;
    ack   = 1'b0;
    repeat (3) tick();
    chk("reset_idle", idle, 1);
    chk("reset_busy", busy, 0);
    chk("reset_overflow", overflow, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single word with exact handshake timing
    push(8'hA5);
    chk("single_level", level, 1);
    chk("single_valid_early", handshake_valid, 0);
    tick();
    chk("single_valid", handshake_valid, 1);
    chk("single_data", handshake_data, 8'hA5);
    ack = 1'b1;
    repeat (2) tick();
    chk("ack_valid_hold", handshake_valid, 1);
    tick();
    chk("ack_valid_drop", handshake_valid, 0);
    ack = 1'b0;
    repeat (2) tick();
    chk("release_not_idle", idle, 0);
    tick();
    chk("release_idle", idle, 1);

    // Fill and overflow
    for (int i = 1; i <= 5; i++) begin
      stb  = 1'b1;
      data = 8'(i);
      tick();
    end
    chk("fill_level", level, 4);
    chk("fill_busy", busy, 1);
    chk("fill_inflight", handshake_data, 8'h01);
    data = 8'h06;
    tick();
    stb = 1'b0;
    chk("ovf_pulse", overflow, 1);
    tick();
    chk("ovf_clear", overflow, 0);
    deliver(5);
    chk("fill_idle", idle, 1);

    // Pointer wrap with the queue kept partly full
    auto_ack = 1'b1;
    for (int w = 0; w < 12; w++) begin
      int g = 0;
      while (busy && g < 50) begin
        tick();
        g++;
      end
      push(8'h10 + 8'(w));
      repeat ($urandom_range(0, 4)) tick();
    end
    drain();
    auto_ack = 1'b0;

    // Simultaneous push and pop with level 2
    push(8'h21);
    tick();
    push(8'h22);
    push(8'h23);
    chk("sim_level_pre", level, 2);
    ack = 1'b1;
    repeat (3) tick();
    chk("sim_valid_low", handshake_valid, 0);
    ack = 1'b0;
    repeat (3) tick();
    chk("sim_level_idle", level, 2);
    push(8'h24);
    chk("sim_level_post", level, 2);
    chk("sim_valid", handshake_valid, 1);
    chk("sim_data", handshake_data, 8'h22);
    deliver(3);
    chk("sim_idle", idle, 1);

    // Reset mid-transfer, then first-edge stb drop
    for (int i = 0; i < 4; i++) begin
      stb  = 1'b1;
      data = 8'h31 + 8'(i);
      tick();
    end
    stb = 1'b0;
    chk("mid_level", level, 3);
    chk("mid_valid", handshake_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", handshake_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_idle", idle, 1);
    repeat (2) tick();
    rst_n = 1'b1;
    push(8'h99);
    chk("first_edge_drop", level, 0);
    tick();
    push(8'h77);
    tick();
    chk("post_rst_valid", handshake_valid, 1);
    chk("post_rst_data", handshake_data, 8'h77);
    deliver(1);

    // Spurious ack while idle and empty
    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("spur_valid", handshake_valid, 0);
      chk("spur_level", level, 0);
      chk("spur_overflow", overflow, 0);
    end
    ack = 1'b0;
    repeat (4) tick();
    chk("spur_idle", idle, 1);

    // Random traffic
    auto_ack = 1'b1;
    repeat (400) begin
      stb  = 1'($urandom_range(0, 1));
      data = 8'($urandom);
      tick();
    end
    stb = 1'b0;
    drain();
    auto_ack = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
